masku_operand_sequencer: RTL and testbench
==========================================

// Module: masku_operand_sequencer
// PURPOSE
//  Sequences the mask-unit operand datapath for mask-producing instructions.
//  Sits between the lane operand queues, the combinational operand
//  unpack/compress stage and the mask result queue.
//  Per instruction: drives the compressed-bit pointer (vrf_pnt_o), consumes
//  lockstep operand beats from all lanes, ORs each compressed beat into a
//  result word, and emits full or final words on a valid/ready interface.
// PARAMETERS
//  NrLanes   4   number of lanes; datapath DW = NrLanes*ElenBits bits
//  ElenBits  64  bits per lane operand word (ELEN)
//  VlWidth   16  width of the vector-length field
// PORTS
//  clk_i            in   1                  clock
//  rst_i            in   1                  synchronous reset, active-high
//  vinsn_valid_i    in   1                  new instruction offered
//  vinsn_ready_o    out  1                  instruction accepted (IDLE only)
//  vinsn_vl_i       in   VlWidth            number of elements
//  vinsn_vsew_i     in   2                  SEW: 0=8, 1=16, 2=32, 3=64 bits
//  operand_valid_i  in   NrLanes            per-lane operand beat available
//  operand_ready_o  out  NrLanes            per-lane pop (all lanes together)
//  compressed_i     in   NrLanes*ElenBits   compressed beat at vrf_pnt_o
//  vrf_pnt_o        out  $clog2(DW)+1       next free bit in the result word
//  result_o         out  NrLanes*ElenBits   accumulated mask word
//  result_valid_o   out  1                  result word valid
//  result_ready_i   in   1                  result queue accepts word
//  result_last_o    out  1                  word is last of instruction
//  done_o           out  1                  one-cycle instruction-complete pulse
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; acc, vrf_pnt, remaining cleared.
//  Reset mid-operation aborts the instruction; no done_o, no result emitted.
//  Beat size: EPB = NrLanes*(ElenBits>>(3+vsew)) elements = bits per beat.
//  FSM:
//   IDLE : vinsn_ready_o=1. On vinsn_valid_i, latch vl and vsew into
//          remaining/sew; vrf_pnt=0; acc=0.
//          vl==0 -> done_o=1 next cycle, stay IDLE.
//          vl!=0 -> RUN.
//   RUN  : beat fires when &operand_valid_i. operand_ready_o='1 only in the
//          fire cycle (never partial pops).
//          On fire:
//          - acc |= compressed_i
//          - n = min(remaining, EPB)
//          - remaining -= n
//          - vrf_pnt += n
//          If vrf_pnt+n==DW or remaining-n==0: register result_o=acc|compressed_i,
//          result_valid_o=1, result_last_o=(remaining-n==0); go to FLUSH.
//   FLUSH: no operands popped. Hold result_o, result_valid_o and
//          result_last_o stable until result_ready_i.
//          On handshake: result_valid_o=0; acc=0; vrf_pnt=0.
//          Then: last -> done_o=1 next cycle, go to IDLE; else -> RUN.
//  Latency: accept -> RUN 1 cycle; last beat -> result_valid_o next cycle;
//   result handshake -> done_o next cycle.
//  vrf_pnt_o is registered and stable during a beat. It never exceeds DW;
//   at DW it wraps to 0 only through FLUSH.
//  vsew is sampled at accept; later vinsn_vsew_i changes are ignored.
//  compressed_i bits beyond the current beat are trusted to be 0 (upstream
//   zeroes them); no masking is done here.
//  Simultaneous vinsn_valid_i outside IDLE is ignored (vinsn_ready_o=0).
//  remaining arithmetic is unsigned, VlWidth bits, and never underflows.
// TESTING (NrLanes=4, ElenBits=64, DW=256)
//  vl=256, vsew=0, all valid -> 8 beats, vrf_pnt_o 0,32,..,224; one result
//   with last=1 and result_o = OR of beats; done_o 1 cycle after handshake.
//  vl=10, vsew=3 -> 3 beats (n=4,4,2), vrf_pnt_o 0,4,8; result last=1, done_o.
//  vl=300, vsew=0 -> word1 after 8 beats (last=0), vrf_pnt_o resets to 0;
//   2 beats later word2 (last=1); exactly 10 operand pops total.
//  vl=0 -> vinsn accepted, done_o next cycle, no operand_ready_o, no result.
//  Backpressure: result_ready_i=0 for 5 cycles -> result_* stable, zero pops;
//   one lane invalid -> no lane popped.
//  rst_i asserted mid-RUN (beat 3 of 8) -> next cycle all outputs 0, IDLE;
//   a new vl=32, vsew=0 completes in 1 beat with a clean acc.

Source files
------------

// File: rtl/masku_operand_sequencer.sv
// Mask-unit operand sequencer: pops lockstep lane beats, ORs compressed bits
// into a DW-bit result word and emits full/final words on valid/ready.
module masku_operand_sequencer #(
    parameter int unsigned NrLanes  = 4,
    parameter int unsigned ElenBits = 64,
    parameter int unsigned VlWidth  = 16,
    localparam int unsigned DW      = NrLanes * ElenBits,
    localparam int unsigned PntW    = $clog2(DW) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                vinsn_valid_i,
    output logic                vinsn_ready_o,
    input  logic [VlWidth-1:0]  vinsn_vl_i,
    input  logic [1:0]          vinsn_vsew_i,
    input  logic [NrLanes-1:0]  operand_valid_i,
    output logic [NrLanes-1:0]  operand_ready_o,
    input  logic [DW-1:0]       compressed_i,
    output logic [PntW-1:0]     vrf_pnt_o,
    output logic [DW-1:0]       result_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic                result_last_o,
    output logic                done_o
);

    localparam logic [PntW-1:0] DwPnt = PntW'(DW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

    state_e               state, nxt_state;
    logic [DW-1:0]        acc, nxt_acc;
    logic [PntW-1:0]      vrf_pnt, nxt_pnt;
    logic [VlWidth-1:0]   remaining, nxt_rem;
    logic [1:0]           sew, nxt_sew;
    logic [DW-1:0]        result_q, nxt_result;
    logic                 result_valid_q, nxt_valid;
    logic                 result_last_q, nxt_last;
    logic                 done_q, nxt_done;

    logic [VlWidth-1:0]   epb;
    logic [VlWidth-1:0]   n;
    logic [VlWidth-1:0]   rem_left;
    logic [PntW-1:0]      pnt_sum;
    logic [DW-1:0]        merged;

    always_comb begin
        unique case (sew)
            2'd0:    epb = VlWidth'(NrLanes * (ElenBits >> 3));
            2'd1:    epb = VlWidth'(NrLanes * (ElenBits >> 4));
            2'd2:    epb = VlWidth'(NrLanes * (ElenBits >> 5));
            default: epb = VlWidth'(NrLanes * (ElenBits >> 6));
        endcase
        n        = (remaining < epb) ? remaining : epb;
        rem_left = remaining - n;
        pnt_sum  = vrf_pnt + PntW'(n);
        merged   = acc | compressed_i;
    end

    always_comb begin
        nxt_state       = state;
        nxt_acc         = acc;
        nxt_pnt         = vrf_pnt;
        nxt_rem         = remaining;
        nxt_sew         = sew;
        nxt_result      = result_q;
        nxt_valid       = result_valid_q;
        nxt_last        = result_last_q;
        nxt_done        = 1'b0;
        vinsn_ready_o   = 1'b0;
        operand_ready_o = '0;

        unique case (state)
            IDLE: begin
                vinsn_ready_o = !rst_i;
                if (vinsn_valid_i) begin
                    nxt_rem = vinsn_vl_i;
                    nxt_sew = vinsn_vsew_i;
                    nxt_pnt = '0;
                    nxt_acc = '0;
                    if (vinsn_vl_i == '0) nxt_done = 1'b1;
                    else                  nxt_state = RUN;
                end
            end
            RUN: begin
                // All lanes pop together or not at all.
                if (&operand_valid_i && !rst_i) begin
                    operand_ready_o = '1;
                    nxt_acc         = merged;
                    nxt_rem         = rem_left;
                    nxt_pnt         = pnt_sum;
                    if (pnt_sum == DwPnt || rem_left == '0) begin
                        nxt_result = merged;
                        nxt_valid  = 1'b1;
                        nxt_last   = (rem_left == '0);
                        nxt_state  = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (result_ready_i) begin
                    nxt_valid = 1'b0;
                    nxt_last  = 1'b0;
                    nxt_acc   = '0;
                    nxt_pnt   = '0;
                    if (result_last_q) begin
                        nxt_done  = 1'b1;
                        nxt_state = IDLE;
                    end else begin
                        nxt_state = RUN;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            acc            <= '0;
            vrf_pnt        <= '0;
            remaining      <= '0;
            sew            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_last_q  <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state          <= nxt_state;
            acc            <= nxt_acc;
            vrf_pnt        <= nxt_pnt;
            remaining      <= nxt_rem;
            sew            <= nxt_sew;
            result_q       <= nxt_result;
            result_valid_q <= nxt_valid;
            result_last_q  <= nxt_last;
            done_q         <= nxt_done;
        end
    end

    assign vrf_pnt_o      = vrf_pnt;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign result_last_o  = result_last_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_masku_operand_sequencer.sv
// Randomized bench for masku_operand_sequencer: a per-instruction model derives
// beat sizes, pointers, result words and pop counts from vl/vsew alone.
module tb_masku_operand_sequencer;

    localparam int NL = 4;
    localparam int EB = 64;
    localparam int VW = 16;
    localparam int DW = NL * EB;
    localparam int PW = $clog2(DW) + 1;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           vinsn_valid_i;
    logic           vinsn_ready_o;
    logic [VW-1:0]  vinsn_vl_i;
    logic [1:0]     vinsn_vsew_i;
    logic [NL-1:0]  operand_valid_i;
    logic [NL-1:0]  operand_ready_o;
    logic [DW-1:0]  compressed_i;
    logic [PW-1:0]  vrf_pnt_o;
    logic [DW-1:0]  result_o;
    logic           result_valid_o;
    logic           result_ready_i;
    logic           result_last_o;
    logic           done_o;

    int checks   = 0;
    int failures = 0;

    masku_operand_sequencer #(.NrLanes(NL), .ElenBits(EB), .VlWidth(VW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .vinsn_valid_i   (vinsn_valid_i),
        .vinsn_ready_o   (vinsn_ready_o),
        .vinsn_vl_i      (vinsn_vl_i),
        .vinsn_vsew_i    (vinsn_vsew_i),
        .operand_valid_i (operand_valid_i),
        .operand_ready_o (operand_ready_o),
        .compressed_i    (compressed_i),
        .vrf_pnt_o       (vrf_pnt_o),
        .result_o        (result_o),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .result_last_o   (result_last_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [DW-1:0] span(input int pnt, input int n);
        logic [DW-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return ((one << n) - one) << pnt;
    endfunction

    task automatic idle_inputs();
        vinsn_valid_i   = 1'b0;
        operand_valid_i = '0;
        compressed_i    = '0;
        result_ready_i  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_op_ready"},  256'(operand_ready_o), 256'(0));
        chk({tag, "_vrf_pnt"},   256'(vrf_pnt_o),       256'(0));
        chk({tag, "_result"},    result_o,              256'(0));
        chk({tag, "_res_valid"}, 256'(result_valid_o),  256'(0));
        chk({tag, "_res_last"},  256'(result_last_o),   256'(0));
        chk({tag, "_done"},      256'(done_o),          256'(0));
    endtask

    // abort_at >= 0 asserts reset while waiting on that (0-based) beat.
    task automatic run_insn(input int vl, input int vsew, input int stall_pct,
                            input int bp_pct, input int hold, input int abort_at);
        int epb, rem, pnt, n, pops, exp_pops, beats, budget, fcyc;
        logic [DW-1:0] word, cval;
        logic [NL-1:0] v;
        bit fire, last, hs;

        epb      = (NL * (EB / 8)) >> vsew;
        exp_pops = (vl + epb - 1) / epb;

        vinsn_valid_i = 1'b1;
        vinsn_vl_i    = VW'(vl);
        vinsn_vsew_i  = 2'(vsew);
        #1;
        chk("accept_ready", 256'(vinsn_ready_o), 256'(1));
        chk("accept_done",  256'(done_o),        256'(0));
        tick();
        vinsn_valid_i = 1'b0;
        vinsn_vl_i    = VW'($urandom());
        vinsn_vsew_i  = 2'($urandom());

        if (vl == 0) begin
            chk("vl0_done",      256'(done_o),          256'(1));
            chk("vl0_ready",     256'(vinsn_ready_o),   256'(1));
            chk("vl0_res_valid", 256'(result_valid_o),  256'(0));
            chk("vl0_op_ready",  256'(operand_ready_o), 256'(0));
            tick();
            chk("vl0_done_clr",  256'(done_o),          256'(0));
            return;
        end

        rem = vl; pnt = 0; word = '0; pops = 0; beats = 0;
        while (rem > 0) begin
            n    = (rem < epb) ? rem : epb;
            cval = rand_word() & span(pnt, n);
            fire = 1'b0;
            budget = 0;
            while (!fire) begin
                if (beats == abort_at) begin
                    rst_i           = 1'b1;
                    operand_valid_i = '1;
                    compressed_i    = cval;
                    tick();
                    rst_i = 1'b0;
                    idle_inputs();
                    #1;
                    check_all_zero("abort");
                    chk("abort_idle", 256'(vinsn_ready_o), 256'(1));
                    return;
                end
                v = '1;
                if ($urandom_range(99) < stall_pct && budget < 40) v[$urandom_range(NL-1)] = 1'b0;
                operand_valid_i = v;
                compressed_i    = cval;
                result_ready_i  = 1'($urandom());
                #1;
                fire = &v;
                chk("op_ready",      256'(operand_ready_o), fire ? 256'hF : 256'h0);
                chk("vrf_pnt",       256'(vrf_pnt_o),       256'(pnt));
                chk("run_res_valid", 256'(result_valid_o),  256'(0));
                chk("run_done",      256'(done_o),          256'(0));
                if (operand_ready_o == '1) pops++;
                tick();
                budget++;
            end
            word  |= cval;
            rem   -= n;
            pnt   += n;
            beats++;
            if (pnt == DW || rem == 0) begin
                last = (rem == 0);
                hs   = 1'b0;
                fcyc = 0;
                while (!hs) begin
                    operand_valid_i = '1;
                    compressed_i    = rand_word();
                    result_ready_i  = (fcyc >= hold) &&
                                      ($urandom_range(99) >= bp_pct || fcyc > hold + 40);
                    #1;
                    chk("res_valid",      256'(result_valid_o),  256'(1));
                    chk("result",         result_o,              word);
                    chk("res_last",       256'(result_last_o),   256'(last));
                    chk("flush_op_ready", 256'(operand_ready_o), 256'(0));
                    chk("flush_done",     256'(done_o),          256'(0));
                    if (operand_ready_o == '1) pops++;
                    hs = result_ready_i;
                    tick();
                    fcyc++;
                end
                result_ready_i  = 1'b0;
                operand_valid_i = '0;
                chk("res_valid_clr", 256'(result_valid_o), 256'(0));
                pnt  = 0;
                word = '0;
            end
        end
        chk("done",     256'(done_o), 256'(1));
        chk("pops",     256'(pops),   256'(exp_pops));
        idle_inputs();
        tick();
        chk("done_clr", 256'(done_o), 256'(0));
    endtask

    initial begin
        idle_inputs();
        rst_i        = 1'b1;
        vinsn_vl_i   = '0;
        vinsn_vsew_i = '0;
        repeat (3) tick();
        check_all_zero("reset");
        chk("reset_vinsn_ready", 256'(vinsn_ready_o), 256'(0));
        rst_i = 1'b0;
        tick();

        run_insn(256, 0, 0, 0, 0, -1);
        run_insn(10, 3, 0, 0, 0, -1);
        run_insn(300, 0, 0, 0, 0, -1);
        run_insn(0, 2, 0, 0, 0, -1);
        run_insn(64, 1, 40, 0, 5, -1);
        run_insn(48, 2, 30, 50, 5, -1);
        run_insn(256, 0, 0, 0, 0, 3);
        run_insn(32, 0, 0, 0, 0, -1);

        for (int k = 0; k < 12; k++) begin
            run_insn(int'($urandom_range(600)), int'($urandom_range(3)), 30, 30,
                     int'($urandom_range(3)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
